// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding, parity modes and frame length helper for the UART TX queue
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Total clock cycles occupied by one frame on the line
  function automatic int frame_cycles(input int clk_div, input int data_w,
                                      input int par_bits, input int stop_bits);
    return (1 + data_w + par_bits + stop_bits) * clk_div;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with occupancy-derived full/empty flags
module uart_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  // Storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is read combinationally; a simultaneous write when full lands after the read
  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - queued UART transmitter; parity bit built only with UART_TX_PARITY_EN
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 5,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int STOP_BITS = 1,
`ifdef UART_TX_PARITY_EN
  parameter int PARITY    = PAR_NONE,
`endif
  parameter logic [DATA_W-1:0] CHAR_INIT = DATA_W'('h41)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cnt,
  input  logic              i_push,
  input  logic              i_sed,
  output logic [DATA_W-1:0] o_chr,
  output logic              o_busy,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_ovf,
  output logic              o_txd
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W);

  logic cnt_q, push_q, sed_q;
  logic cnt_ev, push_ev, sed_ev;

  logic [DATA_W-1:0] chr;
  logic [DATA_W-1:0] head;
  logic              full, empty, wr, pop, ovf;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [BIT_W-1:0]  bit_idx;
  logic              stop_idx;
  logic [DATA_W-1:0] shift;
  logic              txd, busy;
  logic              div_end, last_bit, last_stop;
`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = (PARITY != PAR_NONE);
  logic par_bit;
`endif

  assign cnt_ev  = i_cnt  & ~cnt_q;
  assign push_ev = i_push & ~push_q;
  assign sed_ev  = i_sed  & ~sed_q;

  // Previous-sample history for rising-edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= 1'b0;
      push_q <= 1'b0;
      sed_q  <= 1'b0;
    end else begin
      cnt_q  <= i_cnt;
      push_q <= i_push;
      sed_q  <= i_sed;
    end
  end

  // Selected character advances and wraps modulo 2^DATA_W
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) chr <= CHAR_INIT;
    else if (cnt_ev) chr <= chr + 1'b1;
  end

  assign div_end   = (div == DIV_W'(CLK_DIV - 1));
  assign last_bit  = (bit_idx == BIT_W'(DATA_W - 1));
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

  // A new frame starts either from idle on a send event or seamlessly after the last stop bit
  assign pop = !empty && ((state == ST_IDLE && sed_ev) ||
                          (state == ST_STOP && div_end && last_stop));
  // A push while full still succeeds if the head leaves in the same cycle
  assign wr  = push_ev && (!full || pop);

  uart_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (i_clk),
    .rst    (i_rst),
    .wr_en  (wr),
    .wr_data(chr),
    .rd_en  (pop),
    .rd_data(head),
    .full   (full),
    .empty  (empty)
  );

  // Sticky overflow on a dropped push
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ovf <= 1'b0;
    else if (push_ev && full && !pop) ovf <= 1'b1;
  end

  // Frame sequencer with registered line and busy outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      div      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else if (pop) begin
      state <= ST_START;
      txd   <= 1'b0;
      busy  <= 1'b1;
      div   <= '0;
      shift <= head;
`ifdef UART_TX_PARITY_EN
      par_bit <= (PARITY == PAR_ODD) ? ~^head : ^head;
`endif
    end else if (state != ST_IDLE) begin
      if (!div_end) begin
        div <= div + 1'b1;
      end else begin
        div <= '0;
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            txd     <= shift[0];
            bit_idx <= '0;
          end
          ST_DATA: begin
            if (!last_bit) begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              txd     <= shift[1];
`ifdef UART_TX_PARITY_EN
            end else if (HAS_PAR) begin
              state <= ST_PARITY;
              txd   <= par_bit;
`endif
            end else begin
              state    <= ST_STOP;
              txd      <= 1'b1;
              stop_idx <= 1'b0;
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            state    <= ST_STOP;
            txd      <= 1'b1;
            stop_idx <= 1'b0;
          end
`endif
          ST_STOP: begin
            if (!last_stop) begin
              stop_idx <= stop_idx + 1'b1;
            end else begin
              state <= ST_IDLE;
              txd   <= 1'b1;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            txd   <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_chr   = chr;
  assign o_busy  = busy;
  assign o_full  = full;
  assign o_empty = empty;
  assign o_ovf   = ovf;
  assign o_txd   = txd;

endmodule
